// File: rtl/mbist_pkg.sv
// MBIST shared types and defaults.
// Used by the response analyzer and its delay line.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned DEF_WIDTH = 10;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

endpackage

// File: rtl/bist_delay_line.sv
// Valid-tagged shift pipeline for in-flight reads.
// Flush clears every valid tag in one cycle.
module bist_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0] dat [DEPTH];

  assign out_valid = vld[DEPTH-1];
  assign out_data = dat[DEPTH-1];

  // Shift tags and payload one stage per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else begin
      if (flush) begin
        vld <= '0;
      end else begin
        vld[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) begin
          vld[i] <= vld[i-1];
        end
      end
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        dat[i] <= dat[i-1];
      end
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// MBIST read-side checker: delays expected data,
// compares with memory output, keeps fail results.
module bist_response_analyzer
  import mbist_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  NbarT,
  input  logic                  start,
  input  logic                  test_end,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      exp_data,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0]      fail_syndrome,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  localparam int unsigned DW = ADDR_WIDTH + WIDTH;
  localparam int unsigned CW = $clog2(READ_LATENCY + 1);

  state_t state;
  logic [CW-1:0] dcnt;

  logic go;
  logic flush;
  logic push;
  logic cmp;
  logic mism;
  logic dl_valid;
  logic [DW-1:0] dl_data;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_exp;

  assign go = NbarT & start;
  assign flush = ~NbarT | start;
  assign push = go ? 1'b0
              : NbarT & rd_en & (state == RUN);
  assign {d_addr, d_exp} = dl_data;
  assign cmp = dl_valid & NbarT & ~start
             & ((state == RUN) | (state == DRAIN));
  assign mism = cmp & (d_exp != mem_dout);
  assign pass = done & ~fail;

  bist_delay_line #(
    .DEPTH (READ_LATENCY),
    .W     (DW)
  ) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (push),
    .in_data   ({rd_addr, exp_data}),
    .out_valid (dl_valid),
    .out_data  (dl_data)
  );

  // Session FSM; drain lasts exactly one read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      dcnt <= '0;
    end else if (!NbarT) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      state <= RUN;
      busy <= 1'b1;
      done <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (test_end) begin
            state <= DRAIN;
            dcnt <= CW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == CW'(READ_LATENCY)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // First-fail capture and saturating mismatch count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail <= 1'b0;
      fail_addr <= '0;
      fail_syndrome <= '0;
      fail_count <= '0;
    end else if (go) begin
      fail <= 1'b0;
      fail_addr <= '0;
      fail_syndrome <= '0;
      fail_count <= '0;
    end else if (mism) begin
      if (!fail) begin
        fail <= 1'b1;
        fail_addr <= d_addr;
        fail_syndrome <= d_exp ^ mem_dout;
      end
      if (fail_count != '1) begin
        fail_count <= fail_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: latency 1 and
// latency 3 / 2-bit counter instances, shared stimulus.
module tb_bist_response_analyzer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic NbarT = 1'b0;
  logic start = 1'b0;
  logic test_end = 1'b0;
  logic rd_en = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [9:0] exp_data = '0;
  logic [9:0] act_in = '0;
  logic [9:0] mdo1 = '0;
  logic [9:0] mdo3 = '0;

  logic b1, dn1, p1, f1;
  logic [4:0] fa1;
  logic [9:0] fs1;
  logic [7:0] fc1;
  logic b3, dn3, p3, f3;
  logic [4:0] fa3;
  logic [9:0] fs3;
  logic [1:0] fc3;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  bist_response_analyzer #(
    .READ_LATENCY (1)
  ) u_d1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .NbarT         (NbarT),
    .start         (start),
    .test_end      (test_end),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .exp_data      (exp_data),
    .mem_dout      (mdo1),
    .busy          (b1),
    .done          (dn1),
    .pass          (p1),
    .fail          (f1),
    .fail_addr     (fa1),
    .fail_syndrome (fs1),
    .fail_count    (fc1)
  );

  bist_response_analyzer #(
    .READ_LATENCY (3),
    .CNT_WIDTH    (2)
  ) u_d3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .NbarT         (NbarT),
    .start         (start),
    .test_end      (test_end),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .exp_data      (exp_data),
    .mem_dout      (mdo3),
    .busy          (b3),
    .done          (dn3),
    .pass          (p3),
    .fail          (f3),
    .fail_addr     (fa3),
    .fail_syndrome (fs3),
    .fail_count    (fc3)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Model: session phase (0 idle,1 run,2 drain,3 done),
  // reads scheduled by the edge number they are due.
  int ph [2];
  bit mf [2];
  logic [4:0] ma [2];
  logic [9:0] ms [2];
  int mc [2];
  int dat [2];
  bit sv [2][16];
  logic [4:0] sa [2][16];
  logic [9:0] se [2][16];
  logic [9:0] sx [2][16];
  int cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        ph[d] = 0; mf[d] = 0; ma[d] = '0;
        ms[d] = '0; mc[d] = 0; dat[d] = 0;
        for (int s = 0; s < 16; s++) sv[d][s] = 0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int lat, cmax, s, w;
        lat = (d == 0) ? 1 : 3;
        cmax = (d == 0) ? 255 : 3;
        s = cyc % 16;
        if (!NbarT || start) begin
          for (int k = 0; k < 16; k++) sv[d][k] = 0;
          if (NbarT) begin
            ph[d] = 1; mf[d] = 0; ma[d] = '0;
            ms[d] = '0; mc[d] = 0;
          end else begin
            ph[d] = 0;
          end
        end else begin
          if (sv[d][s] && (ph[d] == 1 || ph[d] == 2)) begin
            if (se[d][s] != sx[d][s]) begin
              if (!mf[d]) begin
                mf[d] = 1;
                ma[d] = sa[d][s];
                ms[d] = se[d][s] ^ sx[d][s];
              end
              if (mc[d] < cmax) mc[d]++;
            end
            sv[d][s] = 0;
          end
          if (ph[d] == 1) begin
            if (rd_en) begin
              w = (cyc + lat) % 16;
              sv[d][w] = 1;
              sa[d][w] = rd_addr;
              se[d][w] = exp_data;
              sx[d][w] = act_in;
            end
            if (test_end) begin
              ph[d] = 2;
              dat[d] = cyc + lat;
            end
          end else if (ph[d] == 2 && cyc == dat[d]) begin
            ph[d] = 3;
          end
        end
      end
    end
  end

  // Memory returns the scheduled word just before it is due
  always @(posedge clk) begin
    #2;
    mdo1 = sv[0][(cyc+1)%16] ? sx[0][(cyc+1)%16] : '0;
    mdo3 = sv[1][(cyc+1)%16] ? sx[1][(cyc+1)%16] : '0;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("d1_busy", b1, ph[0] == 1 || ph[0] == 2);
      chk("d1_done", dn1, ph[0] == 3);
      chk("d1_pass", p1, ph[0] == 3 && !mf[0]);
      chk("d1_fail", f1, mf[0]);
      chk("d1_addr", fa1, ma[0]);
      chk("d1_synd", fs1, ms[0]);
      chk("d1_cnt", fc1, mc[0]);
      chk("d3_busy", b3, ph[1] == 1 || ph[1] == 2);
      chk("d3_done", dn3, ph[1] == 3);
      chk("d3_pass", p3, ph[1] == 3 && !mf[1]);
      chk("d3_fail", f3, mf[1]);
      chk("d3_addr", fa3, ma[1]);
      chk("d3_synd", fs3, ms[1]);
      chk("d3_cnt", fc3, mc[1]);
    end
  end

  task automatic drv(input bit nb, input bit st,
                     input bit te, input bit rd,
                     input logic [4:0] a,
                     input logic [9:0] e,
                     input logic [9:0] x);
    @(posedge clk);
    #1;
    NbarT = nb; start = st; test_end = te;
    rd_en = rd; rd_addr = a;
    exp_data = e; act_in = x;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1;
    chk("rst_busy", b1, 0);
    chk("rst_done", dn1, 0);
    chk("rst_cnt3", fc3, 0);

    // clean session
    drv(1, 1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++)
      drv(1, 0, 0, 1, 5'(i), 10'h155, 10'h155);
    drv(1, 0, 1, 0, '0, '0, '0);
    idle(1);
    chk("clean_notyet", dn1, 0);
    idle(1);
    chk("clean_done", dn1, 1);
    chk("clean_pass", p1, 1);
    idle(4);
    chk("clean_cnt", fc1, 0);
    chk("clean_pass3", p3, 1);

    // single fault
    drv(1, 1, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 1, 5'd7, 10'h3FF, 10'h3FB);
    drv(1, 0, 1, 0, '0, '0, '0);
    idle(6);
    chk("one_addr", fa1, 7);
    chk("one_synd", fs1, 10'h004);
    chk("one_cnt", fc1, 1);
    chk("one_pass", p1, 0);
    chk("one_done", dn1, 1);

    // multiple faults
    drv(1, 1, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 1, 5'd2, 10'h0AA, 10'h0AB);
    drv(1, 0, 0, 1, 5'd5, 10'h111, 10'h111);
    drv(1, 0, 0, 1, 5'd9, 10'h000, 10'h3FF);
    drv(1, 0, 0, 1, 5'd12, 10'h123, 10'h321);
    drv(1, 0, 1, 0, '0, '0, '0);
    idle(6);
    chk("multi_addr", fa1, 2);
    chk("multi_synd", fs1, 10'h001);
    chk("multi_cnt", fc1, 3);
    chk("multi_addr3", fa3, 2);

    // saturation, test_end with the last read
    drv(1, 1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 5; i++)
      drv(1, 0, i == 4, 1, 5'(i), 10'h000, 10'h200);
    idle(6);
    chk("sat_cnt3", fc3, 3);
    chk("sat_cnt1", fc1, 5);
    idle(2);
    chk("sat_hold3", fc3, 3);

    // latency 3 drain timing
    drv(1, 1, 0, 0, '0, '0, '0);
    drv(1, 0, 1, 1, 5'd4, 10'h0F0, 10'h0F1);
    idle(1);
    chk("drain_busy", b3, 1);
    idle(1);
    chk("drain_d1", dn3, 0);
    idle(1);
    chk("drain_d2", dn3, 0);
    idle(1);
    chk("drain_done", dn3, 1);
    chk("drain_fail", f3, 1);
    chk("drain_addr", fa3, 4);

    // NbarT drop with reads in flight
    drv(1, 1, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 1, 5'd1, 10'h00F, 10'h00E);
    idle(3);
    drv(1, 0, 0, 1, 5'd20, 10'h001, 10'h002);
    drv(1, 0, 0, 1, 5'd21, 10'h001, 10'h003);
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(0, 1, 0, 0, '0, '0, '0);
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(0, 0, 0, 0, '0, '0, '0);
    chk("abort_cnt3", fc3, 1);
    chk("abort_addr3", fa3, 1);
    chk("abort_busy3", b3, 0);
    chk("abort_cnt1", fc1, 2);

    // asynchronous reset mid-run
    drv(1, 1, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 1, 5'd3, 10'h010, 10'h000);
    drv(1, 0, 0, 1, 5'd6, 10'h010, 10'h000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", b1, 0);
    chk("arst_fail", f1, 0);
    chk("arst_addr", fa1, 0);
    chk("arst_cnt", fc1, 0);
    chk("arst_busy3", b3, 0);
    chk("arst_synd3", fs3, 0);
    #2 rst_n = 1'b1;
    idle(4);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
